// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch state, word size and halt encoding
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] WORD_BYTES         = 32'd4;
  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFC00_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// rtl/fetch_unit_pc_reg.sv - program counter with redirect priority mux and sticky alignment flag
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        redirect,
  output logic        align_err
);

  logic [31:0] pc_q, pc_d;
  logic        align_err_q, align_err_d;
  logic [31:0] target;

  always_comb begin
    target      = jump ? jump_target : branch_target;
    redirect    = run_en & (jump | branch_taken);
    pc_d        = pc_q;
    align_err_d = align_err_q;
    if (run_en) begin
      // A redirect wins over a stall so a taken branch is never lost
      if (redirect) begin
        pc_d = align_word(target);
        if (target[1:0] != 2'b00) align_err_d = 1'b1;
      end else if (!stall) begin
        pc_d = pc_q + WORD_BYTES;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      align_err_q <= align_err_d;
    end
  end

  assign pc        = pc_q;
  assign align_err = align_err_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: boot/run/halt control and IF/ID pipeline register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] Address,
  input  logic [31:0] Instr,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPC,
  output logic [31:0] IfIdPCPlus4,
  output logic        IfIdValid,
  output logic        AlignErr,
  output logic        Halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  if_id_instr_q, if_id_instr_d;
  logic [31:0]  if_id_pc_q, if_id_pc_d;
  logic [31:0]  if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic         if_id_valid_q, if_id_valid_d;
  logic [31:0]  pc;
  logic         redirect;
  logic         run_en;

  assign run_en = (state_q == FETCH_RUN);

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (Clk),
    .rst_n        (Rst_n),
    .run_en       (run_en),
    .stall        (Stall),
    .jump         (Jump),
    .jump_target  (JumpTarget),
    .branch_taken (BranchTaken),
    .branch_target(BranchTarget),
    .pc           (pc),
    .redirect     (redirect),
    .align_err    (AlignErr)
  );

  always_comb begin
    state_d          = state_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_valid_d    = if_id_valid_q;
    case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN: begin
        if (Flush || redirect) begin
          if_id_instr_d = '0;
          if_id_valid_d = 1'b0;
        end else if (!Stall) begin
          if_id_instr_d    = Instr;
          if_id_pc_d       = pc;
          if_id_pc_plus4_d = pc + WORD_BYTES;
          if_id_valid_d    = 1'b1;
          if (Instr == HALT_INSTR) state_d = FETCH_HALT;
        end
      end
      FETCH_HALT: begin
        // The halt instruction stays visible for one cycle, then bubbles forever
        if_id_instr_d = '0;
        if_id_valid_d = 1'b0;
      end
      default: state_d = FETCH_BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q          <= FETCH_BOOT;
      if_id_instr_q    <= '0;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_valid_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_valid_q    <= if_id_valid_d;
    end
  end

  assign Address     = pc;
  assign IfIdInstr   = if_id_instr_q;
  assign IfIdPC      = if_id_pc_q;
  assign IfIdPCPlus4 = if_id_pc_plus4_q;
  assign IfIdValid   = if_id_valid_q;
  assign Halted      = (state_q == FETCH_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit against a preloaded instruction memory
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Stall, Flush, BranchTaken, Jump;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] Address, Instr;
  logic [31:0] IfIdInstr, IfIdPC, IfIdPCPlus4;
  logic        IfIdValid, AlignErr, Halted;
  logic [31:0] mem [16];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 Clk = ~Clk;

  assign Instr = mem[Address[5:2]];

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .HALT_INSTR(HALT)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Stall       (Stall),
    .Flush       (Flush),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .Jump        (Jump),
    .JumpTarget  (JumpTarget),
    .Address     (Address),
    .Instr       (Instr),
    .IfIdInstr   (IfIdInstr),
    .IfIdPC      (IfIdPC),
    .IfIdPCPlus4 (IfIdPCPlus4),
    .IfIdValid   (IfIdValid),
    .AlignErr    (AlignErr),
    .Halted      (Halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] pc4, input logic valid,
                            input logic aerr, input logic halted);
    check({tag, ".addr"},  Address, addr);
    check({tag, ".instr"}, IfIdInstr, instr);
    check({tag, ".pc"},    IfIdPC, pc);
    check({tag, ".pc4"},   IfIdPCPlus4, pc4);
    check({tag, ".valid"}, {31'd0, IfIdValid}, {31'd0, valid});
    check({tag, ".aerr"},  {31'd0, AlignErr}, {31'd0, aerr});
    check({tag, ".halt"},  {31'd0, Halted}, {31'd0, halted});
  endtask

  task automatic clear_inputs();
    Stall = 0; Flush = 0; BranchTaken = 0; Jump = 0;
    BranchTarget = '0; JumpTarget = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_000A;
    mem[2] = 32'h0109_5020;
    mem[3] = HALT;
    clear_inputs();
    Rst_n = 1'b0;
    #1;
    expect_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

    // free run
    step(); Rst_n = 1'b1;
    step(); expect_all("boot",  32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(); expect_all("run0",  32'h4, 32'h2008_0005, 32'h0, 32'h4, 1, 0, 0);
    step(); expect_all("run1",  32'h8, 32'h2009_000A, 32'h4, 32'h8, 1, 0, 0);
    step(); expect_all("run2",  32'hC, 32'h0109_5020, 32'h8, 32'hC, 1, 0, 0);

    // reset with redirect and stall pending, before halt is captured
    Stall = 1; Jump = 1; JumpTarget = 32'h0000_0022;
    Rst_n = 1'b0;
    #1;
    expect_all("rst_mid", 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(); clear_inputs(); Rst_n = 1'b1;
    step(); expect_all("boot2", 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(); expect_all("run0b", 32'h4, 32'h2008_0005, 32'h0, 32'h4, 1, 0, 0);

    // stall two cycles at Address 4
    Stall = 1;
    step(); expect_all("stall1", 32'h4, 32'h2008_0005, 32'h0, 32'h4, 1, 0, 0);
    step(); expect_all("stall2", 32'h4, 32'h2008_0005, 32'h0, 32'h4, 1, 0, 0);
    Stall = 0;
    step(); expect_all("resume", 32'h8, 32'h2009_000A, 32'h4, 32'h8, 1, 0, 0);

    // branch overrides stall
    BranchTaken = 1; BranchTarget = 32'h0; Stall = 1;
    step(); expect_all("branch", 32'h0, 32'h0, 32'h4, 32'h8, 0, 0, 0);
    clear_inputs();

    // jump over branch, misaligned target
    Jump = 1; JumpTarget = 32'h0000_0006; BranchTaken = 1; BranchTarget = 32'h0000_0040;
    step(); expect_all("jump", 32'h4, 32'h0, 32'h4, 32'h8, 0, 1, 0);
    clear_inputs();
    step(); expect_all("post_jump", 32'h8, 32'h2009_000A, 32'h4, 32'h8, 1, 1, 0);
    step(); expect_all("to_c", 32'hC, 32'h0109_5020, 32'h8, 32'hC, 1, 1, 0);

    // flush overrides stall
    Flush = 1; Stall = 1;
    step(); expect_all("flush", 32'hC, 32'h0, 32'h8, 32'hC, 0, 1, 0);
    clear_inputs();

    // capture halt, then inputs ignored
    step(); expect_all("halt_cap", 32'h10, HALT, 32'hC, 32'h10, 1, 1, 1);
    Jump = 1; JumpTarget = 32'h0000_0100; BranchTaken = 1;
    step(); expect_all("halt1", 32'h10, 32'h0, 32'hC, 32'h10, 0, 1, 1);
    step(); expect_all("halt2", 32'h10, 32'h0, 32'hC, 32'h10, 0, 1, 1);

    // asynchronous reset pulse mid-halt
    Rst_n = 1'b0;
    #1;
    expect_all("rst_halt", 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(); clear_inputs(); Rst_n = 1'b1;
    step(); expect_all("boot3", 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

    // PC+4 wrap at top of address space
    Jump = 1; JumpTarget = 32'hFFFF_FFFC;
    step(); expect_all("jmp_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    clear_inputs();
    step(); expect_all("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 0, 0);
    step(); expect_all("wrap_run", 32'h4, 32'h2008_0005, 32'h0, 32'h4, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
